// File: rtl/seed_pkg.sv
// Shared types and constants for the SEED round sequencing controller.
package seed_pkg;

    localparam int SEED_ROUNDS           = 16;
    localparam int SEED_OUT_BYTES        = 16;
    localparam int SEED_MAX_ROUND_CYCLES = 8;
    localparam int SEED_SUB_W            = $clog2(SEED_MAX_ROUND_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_SEND,
        S_DONE
    } seed_ctrl_state_t;

endpackage

// File: rtl/seed_out_sequencer.sv
// Serialises the 128-bit result to the host one byte per host_ack,
// starting from byte 0 (bits [127:120]) after the final swap.
module seed_out_sequencer
    import seed_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       start,
    input  logic       host_ack,
    output logic [3:0] byte_sel,
    output logic       load_rpi3,
    output logic       last_ack
);

    localparam logic [3:0] LAST_BYTE = 4'(SEED_OUT_BYTES - 1);

    logic accept;

    // host_ack only counts while a byte is actually presented
    assign accept   = load_rpi3 && host_ack;
    assign last_ack = accept && (byte_sel == LAST_BYTE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_sel  <= '0;
            load_rpi3 <= 1'b0;
        end else if (clear) begin
            byte_sel  <= '0;
            load_rpi3 <= 1'b0;
        end else if (start) begin
            byte_sel  <= '0;
            load_rpi3 <= 1'b1;
        end else if (last_ack) begin
            byte_sel  <= '0;
            load_rpi3 <= 1'b0;
        end else if (accept) begin
            byte_sel  <= byte_sel + 4'd1;
        end
    end

endmodule

// File: rtl/seed_round_ctrl.sv
// SEED sequencing controller: captures a block, steps 16 Feistel rounds with
// the encrypt/decrypt subkey order, then hands off to the byte serialiser.
module seed_round_ctrl
    import seed_pkg::*;
#(
    parameter int ROUND_CYCLES = 1,
    parameter int NUM_ROUNDS   = SEED_ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en,
    input  logic       blk_valid,
    input  logic       Enc_Dec,
    input  logic       host_ack,
    output logic       blk_ack,
    output logic       dp_load,
    output logic [3:0] round,
    output logic [3:0] key_idx,
    output logic       round_en,
    output logic       final_swap,
    output logic [3:0] byte_sel,
    output logic       load_rpi3,
    output logic       done,
    output logic       busy
);

    localparam logic [SEED_SUB_W-1:0] SUB_LAST   = SEED_SUB_W'(ROUND_CYCLES - 1);
    localparam logic [3:0]            LAST_ROUND = 4'(NUM_ROUNDS - 1);

    seed_ctrl_state_t state_q, state_d;
    logic [3:0]            round_q, round_d;
    logic [SEED_SUB_W-1:0] sub_q, sub_d;
    logic                  enc_q;
    logic                  last_ack;
    logic                  in_rounds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= '0;
            sub_q   <= '0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            sub_q   <= sub_d;
            // Tracks Enc_Dec up to the end of LOAD so key_idx is already
            // correct during LOAD without a combinational input path.
            if (state_q == S_IDLE || state_q == S_LOAD)
                enc_q <= Enc_Dec;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = '0;
        sub_d   = '0;
        case (state_q)
            S_IDLE:  if (in_en && blk_valid) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: begin
                round_d = round_q;
                if (sub_q == SUB_LAST) begin
                    // Last round holds its index into FINAL instead of wrapping
                    if (round_q == LAST_ROUND) state_d = S_FINAL;
                    else                       round_d = round_q + 4'd1;
                end else begin
                    sub_d = sub_q + SEED_SUB_W'(1);
                end
            end
            S_FINAL: begin
                round_d = round_q;
                state_d = S_SEND;
            end
            S_SEND:  if (last_ack) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!in_en) state_d = S_IDLE;
    end

    assign in_rounds  = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign blk_ack    = (state_q == S_LOAD);
    assign dp_load    = (state_q == S_LOAD);
    assign round_en   = (state_q == S_ROUND) && (sub_q == SUB_LAST);
    assign final_swap = (state_q == S_FINAL);
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign round      = in_rounds ? round_q : 4'd0;

    always_comb begin
        key_idx = 4'd0;
        if (in_rounds)
            key_idx = enc_q ? round_q : (LAST_ROUND - round_q);
        else if (state_q == S_LOAD && !enc_q)
            key_idx = LAST_ROUND;
    end

    seed_out_sequencer u_out (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_en),
        .start    (final_swap),
        .host_ack (host_ack),
        .byte_sel (byte_sel),
        .load_rpi3(load_rpi3),
        .last_ack (last_ack)
    );

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Directed bench for seed_round_ctrl: one instance at ROUND_CYCLES=1, one at 3.
module tb_seed_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       in_en = 0, blk_valid = 0, Enc_Dec = 0, host_ack = 0;
    logic       blk_ack, dp_load, round_en, final_swap, load_rpi3, done, busy;
    logic [3:0] round, key_idx, byte_sel;

    logic       in_en3 = 0, blk_valid3 = 0, Enc_Dec3 = 0, host_ack3 = 0;
    logic       blk_ack3, dp_load3, round_en3, final_swap3, load_rpi33, done3, busy3;
    logic [3:0] round3, key_idx3, byte_sel3;

    logic [19:0] outs;
    assign outs = {blk_ack, dp_load, round, key_idx, round_en, final_swap,
                   byte_sel, load_rpi3, done, busy};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seed_round_ctrl #(.ROUND_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_en(in_en), .blk_valid(blk_valid),
        .Enc_Dec(Enc_Dec), .host_ack(host_ack), .blk_ack(blk_ack),
        .dp_load(dp_load), .round(round), .key_idx(key_idx),
        .round_en(round_en), .final_swap(final_swap), .byte_sel(byte_sel),
        .load_rpi3(load_rpi3), .done(done), .busy(busy)
    );

    seed_round_ctrl #(.ROUND_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_en(in_en3), .blk_valid(blk_valid3),
        .Enc_Dec(Enc_Dec3), .host_ack(host_ack3), .blk_ack(blk_ack3),
        .dp_load(dp_load3), .round(round3), .key_idx(key_idx3),
        .round_en(round_en3), .final_swap(final_swap3), .byte_sel(byte_sel3),
        .load_rpi3(load_rpi33), .done(done3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nack, ack1, ack2, re_cnt, first_re, last_re, fs_cyc, nbytes, done_cyc, ndone;
        int stall, acked, bad;

        // ---------------- reset state
        #1;
        check("reset_outs", 32'(outs), 0);
        check("reset_outs_dut3", 32'({blk_ack3, round3, key_idx3, byte_sel3, load_rpi33, busy3}), 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 0);

        // ---------------- encrypt, RC=1, host_ack high, blk_valid held high
        in_en = 1; blk_valid = 1; Enc_Dec = 1; host_ack = 1;
        step();
        nack = 0; ack1 = 0; ack2 = 0; re_cnt = 0; first_re = 0;
        fs_cyc = 0; nbytes = 0; done_cyc = 0; ndone = 0;
        for (int n = 1; n <= 37; n++) begin
            if (n == 1) begin
                check("load_dp_load", 32'(dp_load), 1);
                check("load_key_idx_enc", 32'(key_idx), 0);
            end
            if (blk_ack) begin
                nack++;
                if (nack == 1) ack1 = n; else ack2 = n;
            end
            if (round_en) begin
                if (re_cnt == 0) first_re = n;
                check("key_idx_enc", 32'(key_idx), 32'(re_cnt));
                re_cnt++;
            end
            if (final_swap) fs_cyc = n;
            if (load_rpi3) begin
                check("byte_sel_seq", 32'(byte_sel), 32'(nbytes));
                nbytes++;
            end
            if (done) begin done_cyc = n; ndone++; end
            if (n < 37) step();
        end
        check("blk_ack_first", 32'(ack1), 1);
        check("blk_ack_second", 32'(ack2), 37);
        check("blk_ack_count", 32'(nack), 2);
        check("first_round_en", 32'(first_re), 2);
        check("round_en_count", 32'(re_cnt), 16);
        check("final_swap_cycle", 32'(fs_cyc), 18);
        check("bytes_sent", 32'(nbytes), 16);
        check("done_cycle", 32'(done_cyc), 35);
        check("done_count", 32'(ndone), 1);
        in_en = 0; blk_valid = 0;
        step();
        check("enc_abort_idle", 32'(busy), 0);

        // ---------------- decrypt, RC=3, Enc_Dec toggled mid-ROUND
        in_en3 = 1; blk_valid3 = 1; Enc_Dec3 = 0; host_ack3 = 1;
        step();
        check("load_key_idx_dec", 32'(key_idx3), 15);
        blk_valid3 = 0;
        re_cnt = 0; first_re = 0; last_re = 0; fs_cyc = 0; done_cyc = 0; ndone = 0; bad = 0;
        for (int n = 1; n <= 68; n++) begin
            if (n == 10) Enc_Dec3 = 1;
            if (round_en3) begin
                if (re_cnt == 0) first_re = n;
                else if (n - last_re != 3) bad++;
                check("key_idx_dec", 32'(key_idx3), 32'(15 - re_cnt));
                last_re = n;
                re_cnt++;
            end
            if (final_swap3) fs_cyc = n;
            if (done3) begin done_cyc = n; ndone++; end
            if (n < 68) step();
        end
        check("dec_first_round_en", 32'(first_re), 4);
        check("dec_round_en_spacing", 32'(bad), 0);
        check("dec_round_en_count", 32'(re_cnt), 16);
        check("dec_final_swap_cycle", 32'(fs_cyc), 50);
        check("dec_done_cycle", 32'(done_cyc), 67);
        check("dec_done_count", 32'(ndone), 1);
        in_en3 = 0; Enc_Dec3 = 0;

        // ---------------- host stall of 5 cycles on byte 7
        in_en = 1; blk_valid = 1; Enc_Dec = 1; host_ack = 1;
        step();
        blk_valid = 0;
        stall = 0; acked = 0; ndone = 0; done_cyc = 0;
        for (int n = 1; n <= 45; n++) begin
            if (load_rpi3 && byte_sel == 4'd7 && stall < 5) begin
                host_ack = 0;
                stall++;
                check("stall_valid", 32'(load_rpi3), 1);
                check("stall_hold", 32'(byte_sel), 7);
            end else begin
                host_ack = 1;
            end
            #1;
            if (load_rpi3 && host_ack) acked++;
            if (done) begin ndone++; done_cyc = n; end
            step();
        end
        check("stall_cycles", 32'(stall), 5);
        check("stall_bytes", 32'(acked), 16);
        check("stall_done_count", 32'(ndone), 1);
        check("stall_done_cycle", 32'(done_cyc), 40);
        check("stall_idle", 32'(busy), 0);

        // ---------------- abort during round 9, then restart
        in_en = 1; blk_valid = 1; Enc_Dec = 1; host_ack = 1;
        step();
        blk_valid = 0;
        repeat (10) step();
        check("abort_round_before", 32'(round), 9);
        in_en = 0;
        step();
        check("abort_outs", 32'(outs), 0);
        blk_valid = 1;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            if (final_swap || done || busy || blk_ack) bad++;
            step();
        end
        check("abort_quiet", 32'(bad), 0);
        in_en = 1;
        step();
        check("restart_blk_ack", 32'(blk_ack), 1);
        blk_valid = 0;
        repeat (22) step();
        check("send_byte4", 32'(byte_sel), 4);
        check("send_valid", 32'(load_rpi3), 1);

        // ---------------- asynchronous reset mid-SEND
        reset = 1;
        #1;
        check("async_reset_outs", 32'(outs), 0);
        in_en = 0;
        step();
        reset = 0;
        step();
        check("post_reset_outs", 32'(outs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seed_round_ctrl.md
# seed_round_ctrl

Sequencing controller for the SEED block-cipher datapath. It accepts an assembled 256-bit block (128-bit message plus 128-bit key) from the byte-input assembler and drives the 16 Feistel rounds with the correct subkey order for encryption or decryption. It then serialises the 128-bit result to the host one byte at a time using a valid/ack handshake. It sits between the byte-to-256 assembler, the round/key-schedule datapath and the host interface inside the top level.

## Interface
- ROUND_CYCLES, 1, clock cycles per round; legal range 1..8.
- NUM_ROUNDS, 16, Feistel rounds; fixed by the algorithm and not to be overridden.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_en  in  1  block enable; low forces IDLE on the next edge.
- blk_valid  in  1  level; an assembled 256-bit block is available.
- Enc_Dec  in  1  1 = encrypt, 0 = decrypt; sampled only in LOAD.
- host_ack  in  1  host accepted the presented byte.
- blk_ack  out  1  one-cycle pulse; block captured.
- dp_load  out  1  one-cycle pulse, coincident with blk_ack; datapath loads the message and key.
- round  out  4  current round index 0..15.
- key_idx  out  4  subkey index: equals round when encrypting, 15-round when decrypting.
- round_en  out  1  datapath commits one round on this cycle.
- final_swap  out  1  one-cycle pulse; datapath latches the output without swap.
- byte_sel  out  4  output byte index; 0 selects bits [127:120].
- load_rpi3  out  1  output byte valid.
- done  out  1  one-cycle pulse after the last byte is acked.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, ROUND, FINAL, SEND, DONE.
- IDLE → LOAD when in_en and blk_valid are both high.
- LOAD lasts one cycle:
  - assert blk_ack and dp_load;
  - latch Enc_Dec into enc_q;
  - clear round and the sub-counter.
- ROUND:
  - The sub-counter counts 0..ROUND_CYCLES-1.
  - round_en is high only when sub-counter = ROUND_CYCLES-1.
  - round increments on that edge.
  - After round_en fires with round = 15, go to FINAL.
- FINAL lasts one cycle: assert final_swap, clear byte_sel, then go to SEND.
- SEND:
  - load_rpi3 is high.
  - On host_ack, byte_sel increments.
  - host_ack with byte_sel = 15 → DONE.
  - Without host_ack, byte_sel and load_rpi3 hold.
- DONE lasts one cycle: done = 1, then IDLE.
- in_en low in any non-IDLE state → IDLE on the next edge. No done, no further strobes; the datapath contents are don't-care.
- blk_valid outside IDLE is ignored; blk_ack is not asserted.
- host_ack is ignored when load_rpi3 is low.
- Enc_Dec changes after LOAD have no effect.
- round, key_idx and byte_sel are 4-bit; they never wrap within one operation.
- round and key_idx read 0 outside ROUND/FINAL, except that key_idx shows 15 in LOAD when Enc_Dec = 0.

## Timing
- Reset values:
  - state IDLE;
  - round, key_idx and byte_sel = 0;
  - blk_ack, dp_load, round_en, final_swap, load_rpi3, done and busy = 0.
- Reset is asynchronous at assertion. Its deassertion is synchronised upstream, so no internal synchroniser is needed.
- blk_valid is sampled at edge E. LOAD occupies cycle E+1. ROUND occupies E+2 .. E+1+16·ROUND_CYCLES. FINAL occupies E+2+16·ROUND_CYCLES.
- The first load_rpi3 appears at E+3+16·ROUND_CYCLES.
- With host_ack held high, 16 consecutive bytes are transferred and done pulses at E+19+16·ROUND_CYCLES. For ROUND_CYCLES = 1 that is E+35.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package seed_pkg holds:
  - the state enum seed_ctrl_state_t;
  - SEED_ROUNDS = 16;
  - SEED_OUT_BYTES = 16;
  - SEED_MAX_ROUND_CYCLES = 8.
- One sub-module: seed_out_sequencer. It owns byte_sel, load_rpi3 and the host_ack handshake, started by final_swap, and returns last_ack to the main FSM.
- The round and sub-counters stay in seed_round_ctrl.

## Test plan
- Encrypt, ROUND_CYCLES = 1, host_ack tied high:
  - blk_ack at E+1;
  - key_idx runs 0,1,…,15 on consecutive round_en;
  - exactly 16 round_en;
  - final_swap at E+18;
  - byte_sel 0..15;
  - done at E+35.
- Decrypt (Enc_Dec = 0), ROUND_CYCLES = 3:
  - key_idx runs 15,14,…,0;
  - round_en spaced 3 cycles apart;
  - Enc_Dec toggled mid-ROUND does not change key_idx.
- Host stall: host_ack low for 5 cycles on byte 7. Response: byte_sel holds at 7 and load_rpi3 stays high; total bytes acked = 16; done fires once.
- Abort: in_en dropped during round 9. Response: IDLE next edge, busy = 0, no final_swap, no done; a new blk_valid is then accepted normally.
- Reset while in SEND byte 4. Response: all outputs 0 immediately, before the next edge; state IDLE.
- blk_valid held high throughout an operation. Response: exactly one blk_ack per operation; a second blk_ack occurs only after done, on the next IDLE cycle.
